// File: rtl/gemm_mmio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gemm_mmio_pkg
// Brief    : Register map, bit indices and FSM state type for the GEMM MMIO slave.
// Revision : 1.0
// ============================================================================
package gemm_mmio_pkg;

  // Byte offsets inside the 32-byte register window
  localparam logic [4:0] C_OFF_CTRL   = 5'h00;
  localparam logic [4:0] C_OFF_STATUS = 5'h04;
  localparam logic [4:0] C_OFF_A_BASE = 5'h08;
  localparam logic [4:0] C_OFF_B_BASE = 5'h0C;
  localparam logic [4:0] C_OFF_C_BASE = 5'h10;
  localparam logic [4:0] C_OFF_DIMS   = 5'h14;
  localparam logic [4:0] C_OFF_CYCLES = 5'h18;
  localparam logic [4:0] C_OFF_RSVD   = 5'h1C;

  localparam int C_CTRL_START  = 0;
  localparam int C_CTRL_IRQ_EN = 1;
  localparam int C_STAT_BUSY   = 0;
  localparam int C_STAT_DONE   = 1;
  localparam int C_STAT_ERR    = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2
  } gemm_state_t;

endpackage
`default_nettype wire

// File: rtl/gemm_perf_counter.sv
`default_nettype none
// ============================================================================
// Module   : gemm_perf_counter
// Brief    : 32-bit wrapping job-cycle counter with clear priority over enable.
// Revision : 1.0
// ============================================================================
module gemm_perf_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        en,
  output logic [31:0] count
);

  logic [31:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/gemm_mmio_slave.sv
`default_nettype none
// ============================================================================
// Module   : gemm_mmio_slave
// Brief    : CPU-facing register window that configures, launches and tracks
//            the GEMM core. Define GEMM_PERF_CNT_EN to add the CYCLES counter.
// Revision : 1.0
// ============================================================================
module gemm_mmio_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          DIM_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  output logic [31:0]      cpu_rdata,
  output logic             cpu_ack,
  output logic             gemm_start,
  output logic [31:0]      gemm_a_base,
  output logic [31:0]      gemm_b_base,
  output logic [31:0]      gemm_c_base,
  output logic [DIM_W-1:0] gemm_m,
  output logic [DIM_W-1:0] gemm_n,
  output logic [DIM_W-1:0] gemm_k,
  input  logic             gemm_done,
  output logic             irq
);

  import gemm_mmio_pkg::*;

  gemm_state_t      r_state;
  gemm_state_t      w_next;
  logic             r_ack;
  logic [31:0]      r_rdata;
  logic             r_irq_en;
  logic             r_done;
  logic             r_err;
  logic [31:0]      r_a_base;
  logic [31:0]      r_b_base;
  logic [31:0]      r_c_base;
  logic [DIM_W-1:0] r_m;
  logic [DIM_W-1:0] r_n;
  logic [DIM_W-1:0] r_k;

  logic        w_in_win;
  logic        w_accept;
  logic        w_wr;
  logic [4:0]  w_off;
  logic        w_wr_ctrl;
  logic        w_wr_stat;
  logic        w_cfg_wr;
  logic        w_start_req;
  logic        w_busy;
  logic        w_start_idle;
  logic        w_dims_ok;
  logic        w_launch;
  logic        w_done_ok;
  logic        w_err_set;
  logic [31:0] w_rd_mux;
  logic [31:0] w_dims_rd;
  logic [31:0] w_cycles;
  logic        w_unused;

  // A request is taken once; the ack cycle itself never re-accepts
  assign w_in_win = (cpu_addr[31:5] == BASE_ADDR[31:5]);
  assign w_accept = cpu_req & w_in_win & ~r_ack;
  assign w_wr     = w_accept & cpu_we;
  assign w_off    = {cpu_addr[4:2], 2'b00};
  assign w_unused = ^cpu_addr[1:0];

  assign w_wr_ctrl    = w_wr & (w_off == C_OFF_CTRL);
  assign w_wr_stat    = w_wr & (w_off == C_OFF_STATUS);
  assign w_cfg_wr     = w_wr & ((w_off == C_OFF_A_BASE) | (w_off == C_OFF_B_BASE) |
                                (w_off == C_OFF_C_BASE) | (w_off == C_OFF_DIMS));
  assign w_start_req  = w_wr_ctrl & cpu_wdata[C_CTRL_START];
  assign w_busy       = (r_state != IDLE);
  assign w_start_idle = w_start_req & ~w_busy;
  assign w_dims_ok    = (|r_m) & (|r_n) & (|r_k);
  assign w_launch     = w_start_idle & w_dims_ok;
  assign w_done_ok    = gemm_done & (r_state == RUN);

  assign w_err_set = (w_start_idle & ~w_dims_ok)
                   | (w_busy & (w_start_req | w_cfg_wr))
                   | (gemm_done & (r_state != RUN));

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_launch) w_next = LAUNCH;
      LAUNCH:  w_next = RUN;
      RUN:     if (gemm_done) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_dims_rd = '0;
    w_dims_rd[DIM_W-1:0]         = r_m;
    w_dims_rd[2*DIM_W-1:DIM_W]   = r_n;
    w_dims_rd[3*DIM_W-1:2*DIM_W] = r_k;
  end

  always_comb begin
    w_rd_mux = '0;
    case (w_off)
      C_OFF_CTRL:   w_rd_mux[C_CTRL_IRQ_EN] = r_irq_en;
      C_OFF_STATUS: w_rd_mux[2:0] = {r_err, r_done, w_busy};
      C_OFF_A_BASE: w_rd_mux = r_a_base;
      C_OFF_B_BASE: w_rd_mux = r_b_base;
      C_OFF_C_BASE: w_rd_mux = r_c_base;
      C_OFF_DIMS:   w_rd_mux = w_dims_rd;
      C_OFF_CYCLES: w_rd_mux = w_cycles;
      default:      w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ack    <= 1'b0;
      r_rdata  <= '0;
      r_irq_en <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_a_base <= '0;
      r_b_base <= '0;
      r_c_base <= '0;
      r_m      <= '0;
      r_n      <= '0;
      r_k      <= '0;
    end else begin
      r_ack   <= w_accept;
      r_rdata <= (w_accept & ~cpu_we) ? w_rd_mux : '0;

      // A start write rejected while busy drops the whole CTRL write
      if (w_wr_ctrl & ~(w_busy & w_start_req)) begin
        r_irq_en <= cpu_wdata[C_CTRL_IRQ_EN];
      end

      if (w_cfg_wr & ~w_busy) begin
        case (w_off)
          C_OFF_A_BASE: r_a_base <= cpu_wdata;
          C_OFF_B_BASE: r_b_base <= cpu_wdata;
          C_OFF_C_BASE: r_c_base <= cpu_wdata;
          default: begin
            r_m <= cpu_wdata[DIM_W-1:0];
            r_n <= cpu_wdata[2*DIM_W-1:DIM_W];
            r_k <= cpu_wdata[3*DIM_W-1:2*DIM_W];
          end
        endcase
      end

      // Status set events take priority over same-cycle clears
      if (w_done_ok) begin
        r_done <= 1'b1;
      end else if (w_start_idle | (w_wr_stat & cpu_wdata[C_STAT_DONE])) begin
        r_done <= 1'b0;
      end

      if (w_err_set) begin
        r_err <= 1'b1;
      end else if (w_wr_stat & cpu_wdata[C_STAT_ERR]) begin
        r_err <= 1'b0;
      end
    end
  end

`ifdef GEMM_PERF_CNT_EN
  gemm_perf_counter u_perf_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (r_state == LAUNCH),
    .en    (r_state == RUN),
    .count (w_cycles)
  );
`else
  assign w_cycles = '0;
`endif

  assign cpu_ack     = r_ack;
  assign cpu_rdata   = r_rdata;
  assign gemm_start  = (r_state == LAUNCH);
  assign gemm_a_base = r_a_base;
  assign gemm_b_base = r_b_base;
  assign gemm_c_base = r_c_base;
  assign gemm_m      = r_m;
  assign gemm_n      = r_n;
  assign gemm_k      = r_k;
  assign irq         = r_done & r_irq_en;

endmodule
`default_nettype wire

// File: tb/tb_gemm_mmio_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_gemm_mmio_slave
// Brief    : Randomized scenario bench for gemm_mmio_slave against a register-level model.
// Revision : 1.0
// ============================================================================
module tb_gemm_mmio_slave;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_ack;
  logic        gemm_start;
  logic [31:0] gemm_a_base, gemm_b_base, gemm_c_base;
  logic [7:0]  gemm_m, gemm_n, gemm_k;
  logic        gemm_done = 1'b0;
  logic        irq;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int start_cnt = 0;
  int start_cyc = 0;

  // Register-level model
  logic [31:0] m_a, m_b, m_c, m_dims, m_cycles;
  logic        m_irq_en, m_done, m_err, m_busy;

  gemm_mmio_slave #(.BASE_ADDR(BASE), .DIM_W(8)) dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .gemm_start(gemm_start),
    .gemm_a_base(gemm_a_base), .gemm_b_base(gemm_b_base), .gemm_c_base(gemm_c_base),
    .gemm_m(gemm_m), .gemm_n(gemm_n), .gemm_k(gemm_k), .gemm_done(gemm_done), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (gemm_start === 1'b1) begin start_cnt++; start_cyc = cyc; end

  function automatic void model_reset();
    m_a = '0; m_b = '0; m_c = '0; m_dims = '0; m_cycles = '0;
    m_irq_en = 0; m_done = 0; m_err = 0; m_busy = 0;
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] off);
    case (off)
      5'h00:   return {30'd0, m_irq_en, 1'b0};
      5'h04:   return {29'd0, m_err, m_done, m_busy};
      5'h08:   return m_a;
      5'h0C:   return m_b;
      5'h10:   return m_c;
      5'h14:   return m_dims;
      5'h18:   return m_cycles;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] job_cycles(input int len);
`ifdef GEMM_PERF_CNT_EN
    return len;
`else
    return (len > 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd, output int lat, output logic ack_next);
    lat = 0; rd = '0; ack_next = 1'b0;
    @(negedge clk); cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    do begin @(posedge clk); #1; lat++; end while (cpu_ack !== 1'b1 && lat < 8);
    if (cpu_ack !== 1'b1) begin
      vectors++; miscompares++;
      $display("FAIL bus_timeout addr=%h: no ack after %0d cycles, required ack", addr, lat);
    end
    rd = cpu_rdata;
    @(negedge clk); cpu_req = 0; cpu_we = 0;
    @(posedge clk); #1; ack_next = cpu_ack;
  endtask

  task automatic wr(input logic [4:0] off, input logic [31:0] d);
    logic [31:0] rd; int lat; logic an;
    bus(1'b1, BASE + {27'd0, off}, d, rd, lat, an);
  endtask

  task automatic rdreg(input logic [4:0] off, output logic [31:0] d);
    int lat; logic an;
    bus(1'b0, BASE + {27'd0, off}, 32'd0, d, lat, an);
  endtask

  // Waits until the negedge of the given tb cycle number
  task automatic wait_to(input int target);
    int g = 0;
    @(negedge clk);
    while (cyc < target && g < 500) begin @(negedge clk); g++; end
    if (cyc != target) begin
      vectors++; miscompares++;
      $display("FAIL sync: at cycle %0d, required cycle %0d", cyc, target);
    end
  endtask

  task automatic launch();
    wr(5'h00, 32'h3);
    m_irq_en = 1; m_done = 0; m_busy = 1;
  endtask

  task automatic pulse_done_at(input int target);
    wait_to(target);
    gemm_done = 1;
    @(negedge clk); gemm_done = 0;
  endtask

  task automatic test_reset();
    logic [31:0] rd; int lat; logic an;
    reset = 1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({gemm_start, irq, cpu_ack, cpu_rdata, gemm_a_base, gemm_b_base, gemm_c_base,
         gemm_m, gemm_n, gemm_k} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: start=%b irq=%b ack=%b a=%h m=%h, required all 0",
               gemm_start, irq, cpu_ack, gemm_a_base, gemm_m);
    end
    @(negedge clk); reset = 0;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      bus(1'b0, BASE + 32'(i * 4), 32'd0, rd, lat, an);
      vectors++;
      if (rd !== 32'd0 || lat != 1 || an !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_read off=%0h: rdata=%h lat=%0d ack_next=%b, required 0/1/0",
                 i * 4, rd, lat, an);
      end
    end
  endtask

  task automatic test_random_regs();
    logic [4:0] off; logic [31:0] d, rd; int lat; logic an;
    for (int i = 0; i < 24; i++) begin
      off = 5'(($urandom % 8) * 4);
      d = $urandom;
      if (off == 5'h00) d[0] = 1'b0;
      bus(1'b1, BASE + {27'd0, off} + ($urandom % 4), d, rd, lat, an);
      case (off)
        5'h00: m_irq_en = d[1];
        5'h04: begin if (d[1]) m_done = 0; if (d[2]) m_err = 0; end
        5'h08: m_a = d;
        5'h0C: m_b = d;
        5'h10: m_c = d;
        5'h14: m_dims = d & 32'h00FF_FFFF;
        default: ;
      endcase
      off = 5'(($urandom % 8) * 4);
      rdreg(off, rd);
      vectors++;
      if (rd !== exp_read(off)) begin
        miscompares++;
        $display("FAIL reg_readback off=%h: got %h, required %h", off, rd, exp_read(off));
      end
    end
  endtask

  task automatic test_job();
    logic [31:0] rd; int len, s0;
    for (int it = 0; it < 3; it++) begin
      if (it == 0) begin
        m_a = 32'h1000; m_b = 32'h2000; m_c = 32'h3000; m_dims = 32'h0004_0404; len = 10;
      end else begin
        m_a = $urandom; m_b = $urandom; m_c = $urandom;
        m_dims = {8'd0, 8'(1 + $urandom % 255), 8'(1 + $urandom % 255), 8'(1 + $urandom % 255)};
        len = 6 + ($urandom % 35);
      end
      wr(5'h08, m_a); wr(5'h0C, m_b); wr(5'h10, m_c); wr(5'h14, m_dims);
      s0 = start_cnt;
      launch();
      rdreg(5'h04, rd);
      vectors++;
      if (start_cnt != s0 + 1 || rd !== exp_read(5'h04)) begin
        miscompares++;
        $display("FAIL job_launch it=%0d: starts=%0d status=%h, required %0d/%h",
                 it, start_cnt - s0, rd, 1, exp_read(5'h04));
      end
      vectors++;
      if ({gemm_a_base, gemm_b_base, gemm_c_base, gemm_k, gemm_n, gemm_m} !==
          {m_a, m_b, m_c, m_dims[23:0]}) begin
        miscompares++;
        $display("FAIL job_outputs it=%0d: a=%h b=%h c=%h kmn=%h%h%h, required %h %h %h %h",
                 it, gemm_a_base, gemm_b_base, gemm_c_base, gemm_k, gemm_n, gemm_m,
                 m_a, m_b, m_c, m_dims[23:0]);
      end
      pulse_done_at(start_cyc + len);
      m_done = 1; m_busy = 0; m_cycles = job_cycles(len);
      vectors++;
      if (irq !== 1'b1) begin
        miscompares++;
        $display("FAIL job_irq it=%0d: irq=%b, required 1", it, irq);
      end
      rdreg(5'h04, rd);
      vectors++;
      if (rd !== exp_read(5'h04) || start_cnt != s0 + 1) begin
        miscompares++;
        $display("FAIL job_status it=%0d: status=%h starts=%0d, required %h/1",
                 it, rd, start_cnt - s0, exp_read(5'h04));
      end
      rdreg(5'h18, rd);
      vectors++;
      if (rd !== m_cycles) begin
        miscompares++;
        $display("FAIL job_cycles it=%0d len=%0d: got %0d, required %0d", it, len, rd, m_cycles);
      end
    end
  endtask

  task automatic test_bad_dims();
    logic [31:0] rd; int s0;
    for (int z = 0; z < 3; z++) begin
      m_dims = {8'd0, 8'(1 + $urandom % 255), 8'(1 + $urandom % 255), 8'(1 + $urandom % 255)};
      m_dims[z*8 +: 8] = 8'd0;
      wr(5'h14, m_dims);
      s0 = start_cnt;
      wr(5'h00, 32'h1);
      m_irq_en = 0; m_done = 0; m_err = 1;
      rdreg(5'h04, rd);
      vectors++;
      if (rd !== 32'h4 || start_cnt != s0 || irq !== 1'b0) begin
        miscompares++;
        $display("FAIL bad_dims zero_field=%0d: status=%h starts=%0d irq=%b, required 4/0/0",
                 z, rd, start_cnt - s0, irq);
      end
      wr(5'h04, 32'h4);
      m_err = 0;
      rdreg(5'h04, rd);
      vectors++;
      if (rd !== exp_read(5'h04)) begin
        miscompares++;
        $display("FAIL err_w1c: status=%h, required %h", rd, exp_read(5'h04));
      end
    end
  endtask

  task automatic test_busy_writes();
    logic [31:0] rd, a_old; logic [7:0] m_old; int s0;
    m_a = $urandom; a_old = m_a;
    m_dims = 32'h0003_0201; m_old = 8'h01;
    wr(5'h08, m_a); wr(5'h14, m_dims);
    s0 = start_cnt;
    launch();
    wr(5'h08, 32'hDEAD);
    wr(5'h00, 32'h1);
    wr(5'h14, 32'h0077_7777);
    m_err = 1;
    rdreg(5'h04, rd);
    vectors++;
    if (rd !== 32'h5 || gemm_a_base !== a_old || gemm_m !== m_old || start_cnt != s0 + 1) begin
      miscompares++;
      $display("FAIL busy_writes: status=%h a=%h m=%h starts=%0d, required 5/%h/%h/1",
               rd, gemm_a_base, gemm_m, start_cnt - s0, a_old, m_old);
    end
    pulse_done_at(start_cyc + 30);
    m_done = 1; m_busy = 0; m_cycles = job_cycles(30);
    rdreg(5'h04, rd);
    vectors++;
    if (rd !== 32'h6 || irq !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_done: status=%h irq=%b, required 6/1", rd, irq);
    end
    wr(5'h04, 32'h6);
    m_done = 0; m_err = 0;
    rdreg(5'h08, rd);
    vectors++;
    if (rd !== a_old || irq !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_a_keep: a=%h irq=%b, required %h/0", rd, irq, a_old);
    end
  endtask

  task automatic test_done_w1c_race();
    logic [31:0] rd;
    m_dims = 32'h0001_0101;
    wr(5'h14, m_dims);
    launch();
    wait_to(start_cyc + 6);
    gemm_done = 1; cpu_req = 1; cpu_we = 1; cpu_addr = BASE + 32'h4; cpu_wdata = 32'h2;
    @(posedge clk); #1;
    vectors++;
    if (cpu_ack !== 1'b1) begin
      miscompares++;
      $display("FAIL race_ack: ack=%b, required 1", cpu_ack);
    end
    @(negedge clk); gemm_done = 0; cpu_req = 0; cpu_we = 0;
    m_done = 1; m_busy = 0; m_cycles = job_cycles(6);
    rdreg(5'h04, rd);
    vectors++;
    if (rd !== exp_read(5'h04)) begin
      miscompares++;
      $display("FAIL race_done: status=%h, required %h", rd, exp_read(5'h04));
    end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] rd;
    m_a = $urandom | 32'h1; m_dims = 32'h0005_0505;
    wr(5'h08, m_a); wr(5'h14, m_dims);
    launch();
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1;
    @(posedge clk); #1;
    vectors++;
    if (gemm_start !== 1'b0 || gemm_a_base !== 32'd0 || irq !== 1'b0 || gemm_m !== 8'd0) begin
      miscompares++;
      $display("FAIL midrun_reset: start=%b a=%h irq=%b m=%h, required 0", gemm_start,
               gemm_a_base, irq, gemm_m);
    end
    @(negedge clk); reset = 0;
    model_reset();
    rdreg(5'h04, rd);
    vectors++;
    if (rd !== 32'd0) begin
      miscompares++;
      $display("FAIL midrun_busy: status=%h, required 0", rd);
    end
    @(negedge clk); gemm_done = 1;
    @(negedge clk); gemm_done = 0;
    m_err = 1;
    rdreg(5'h04, rd);
    vectors++;
    if (rd !== 32'h4) begin
      miscompares++;
      $display("FAIL stray_done: status=%h, required 4", rd);
    end
    wr(5'h04, 32'h4);
    m_err = 0;
  endtask

  task automatic test_back_to_back();
    m_b = $urandom;
    wr(5'h0C, m_b);
    @(negedge clk); cpu_req = 1; cpu_we = 0; cpu_addr = BASE + 32'hC;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (cpu_ack !== ((i % 2) == 0) || (cpu_ack === 1'b1 && cpu_rdata !== m_b)) begin
        miscompares++;
        $display("FAIL back_to_back cyc=%0d: ack=%b rdata=%h, required %b/%h",
                 i, cpu_ack, cpu_rdata, (i % 2) == 0, m_b);
      end
    end
    @(negedge clk); cpu_req = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_out_of_window();
    logic [31:0] addrs [3];
    logic [31:0] rd;
    int acks, s0;
    addrs[0] = BASE + 32'h48;
    addrs[1] = BASE - 32'h18;
    addrs[2] = BASE ^ (32'h1 << (5 + $urandom % 27));
    s0 = start_cnt;
    for (int j = 0; j < 3; j++) begin
      acks = 0;
      @(negedge clk); cpu_req = 1; cpu_we = 1; cpu_addr = addrs[j]; cpu_wdata = 32'h3;
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1;
        if (cpu_ack === 1'b1) acks++;
      end
      @(negedge clk); cpu_req = 0; cpu_we = 0;
      vectors++;
      if (acks != 0) begin
        miscompares++;
        $display("FAIL out_of_window addr=%h: %0d acks, required 0", addrs[j], acks);
      end
    end
    rdreg(5'h08, rd);
    vectors++;
    if (rd !== m_a || start_cnt != s0) begin
      miscompares++;
      $display("FAIL oow_side_effect: a=%h starts=%0d, required %h/0", rd, start_cnt - s0, m_a);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_random_regs();
    test_job();
    test_bad_dims();
    test_busy_writes();
    test_done_w1c_race();
    test_reset_mid_run();
    test_back_to_back();
    test_out_of_window();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
